// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered long-latency results into one
// registered register-file write per cycle, and tracks pending long-latency destinations.
// Optional feature: define WB_BYPASS_EN to let an LSU result skip the empty FIFO.
module wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0] lsu_dest,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_dest,
  input  logic [ADDRESS_WIDTH-1:0] q_rs1,
  input  logic [ADDRESS_WIDTH-1:0] q_rs2,
  output logic                     pend_rs1,
  output logic                     pend_rs2,
  output logic                     rf_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rf_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rf_wrt_data
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] r_fifo_dest [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic [NUM_REGS-1:0]      r_pending;
  logic                     r_wrt_en;
  logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
  logic [DATA_WIDTH-1:0]    r_wrt_data;

  logic                     w_fifo_empty;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_bypass;
  logic                     w_sel_valid;
  logic                     w_sel_lsu;
  logic [ADDRESS_WIDTH-1:0] w_sel_dest;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_set;
  logic [NUM_REGS-1:0]      w_pend_next;

  assign lsu_ready    = (r_count != FULL_CNT);
  assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
  assign w_accept     = lsu_valid & lsu_ready;
  assign w_pop        = ~alu_valid & ~w_fifo_empty;
`ifdef WB_BYPASS_EN
  assign w_bypass     = ~alu_valid & w_fifo_empty & w_accept;
`else
  assign w_bypass     = 1'b0;
`endif
  assign w_push       = w_accept & ~w_bypass;
  assign w_set        = iss_valid & (iss_dest != {ADDRESS_WIDTH{1'b0}});

  // Pick the result for the output register: ALU first, then FIFO head, then bypass.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_lsu   = 1'b0;
    w_sel_dest  = {ADDRESS_WIDTH{1'b0}};
    w_sel_data  = {DATA_WIDTH{1'b0}};
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_dest  = alu_dest;
      w_sel_data  = alu_data;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_lsu   = 1'b1;
      w_sel_dest  = r_fifo_dest[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_lsu   = 1'b1;
      w_sel_dest  = lsu_dest;
      w_sel_data  = lsu_data;
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // Next scoreboard: a new issue overrides a same-cycle clear; entry 0 never pends.
  always_comb begin
    w_pend_next = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      w_pend_next[i] = (w_set && (iss_dest == ADDRESS_WIDTH'(i))) ||
                       (r_pending[i] && !(w_sel_lsu && (w_sel_dest == ADDRESS_WIDTH'(i))));
    end
  end

  // FIFO storage, written at the tail on an accepted non-bypassed transfer.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_dest[r_wr_ptr] <= lsu_dest;
      r_fifo_data[r_wr_ptr] <= lsu_data;
    end
  end

  // Pointers, occupancy, scoreboard and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_pending  <= {NUM_REGS{1'b0}};
      r_wrt_en   <= 1'b0;
      r_wrt_dest <= {ADDRESS_WIDTH{1'b0}};
      r_wrt_data <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_pending <= w_pend_next;
      r_wrt_en  <= w_sel_valid && (w_sel_dest != {ADDRESS_WIDTH{1'b0}});
      if (w_sel_valid) begin
        r_wrt_dest <= w_sel_dest;
        r_wrt_data <= w_sel_data;
      end
    end
  end

  assign pend_rs1    = (q_rs1 != {ADDRESS_WIDTH{1'b0}}) & r_pending[q_rs1];
  assign pend_rs2    = (q_rs2 != {ADDRESS_WIDTH{1'b0}}) & r_pending[q_rs2];
  assign rf_wrt_en   = r_wrt_en;
  assign rf_wrt_dest = r_wrt_dest;
  assign rf_wrt_data = r_wrt_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus hand-written multi-cycle sequences,
// with a write-order scoreboard fed at stimulus time.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef WB_BYPASS_EN
  localparam int LSU_LAT = 1;
`else
  localparam int LSU_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_dest = '0;
  logic [DW-1:0] alu_data = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [AW-1:0] lsu_dest = '0;
  logic [DW-1:0] lsu_data = '0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_dest = '0;
  logic [AW-1:0] q_rs1 = '0;
  logic [AW-1:0] q_rs2 = '0;
  logic          pend_rs1, pend_rs2;
  logic          rf_wrt_en;
  logic [AW-1:0] rf_wrt_dest;
  logic [DW-1:0] rf_wrt_data;

  typedef struct { logic [AW-1:0] dest; logic [DW-1:0] data; } wr_t;
  typedef struct {
    logic av; logic [AW-1:0] ad; logic [DW-1:0] ax;
    logic iv; logic [AW-1:0] id;
    logic [AW-1:0] q; logic exp_en; logic exp_pend;
  } vec_t;

  wr_t  alu_q[$];
  wr_t  lsu_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_alu = 1'b0;
  wr_t  mon_e;
  logic mon_have;
  int   li;
  logic acc;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .rf_wrt_en(rf_wrt_en), .rf_wrt_dest(rf_wrt_dest), .rf_wrt_data(rf_wrt_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_pend(string name, logic [AW-1:0] r, logic e);
    q_rs1 = r;
    q_rs2 = r;
    #1;
    check1({name, "_rs1"}, {31'd0, pend_rs1}, {31'd0, e});
    check1({name, "_rs2"}, {31'd0, pend_rs2}, {31'd0, e});
  endtask

  task automatic set_alu(logic v, logic [AW-1:0] d, logic [DW-1:0] x);
    alu_valid = v;
    alu_dest  = d;
    alu_data  = x;
    if (v && d != 5'd0 && !rst) alu_q.push_back(wr_t'{d, x});
  endtask

  task automatic set_lsu(logic v, logic [AW-1:0] d, logic [DW-1:0] x);
    lsu_valid = v;
    lsu_dest  = d;
    lsu_data  = x;
    if (v && lsu_ready && d != 5'd0 && !rst) lsu_q.push_back(wr_t'{d, x});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_alu(1'b1, 5'd5, 32'h5555_5555);
    set_lsu(1'b1, 5'd4, 32'h4444_4444);
    iss_valid = 1'b1;
    iss_dest  = 5'd4;
    step();
    check1("rst_en", {31'd0, rf_wrt_en}, 32'd0);
    check1("rst_dest", {27'd0, rf_wrt_dest}, 32'd0);
    check1("rst_data", rf_wrt_data, 32'd0);
    step();
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    iss_valid = 1'b0;
    iss_dest  = 5'd0;
    alu_q.delete();
    lsu_q.delete();
  endtask

  // Scoreboard monitor: source of each write follows the ALU-priority rule of the prior edge.
  always @(posedge clk) prev_alu <= alu_valid;

  always @(negedge clk) begin
    if (rf_wrt_en === 1'b1) begin
      mon_have = 1'b0;
      if (prev_alu && alu_q.size() > 0) begin
        mon_e = alu_q.pop_front();
        mon_have = 1'b1;
      end else if (!prev_alu && lsu_q.size() > 0) begin
        mon_e = lsu_q.pop_front();
        mon_have = 1'b1;
      end
      n_checks++;
      if (!mon_have) begin
        n_errors++;
        $display("FAIL wb_unexpected: got dest=%0d data=%0h, expected no write", rf_wrt_dest, rf_wrt_data);
      end else if (rf_wrt_dest !== mon_e.dest || rf_wrt_data !== mon_e.data) begin
        n_errors++;
        $display("FAIL wb_order: got dest=%0d data=%0h expected dest=%0d data=%0h",
                 rf_wrt_dest, rf_wrt_data, mon_e.dest, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_0001, 1'b1, 5'd9, 5'd9,  1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd9,  1'b1, 1'b1};
    vecs[3] = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd0, 5'd0,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b0, 5'd0, 5'd9,  1'b1, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'd0,         1'b0, 5'd0, 5'd31, 1'b0, 1'b0};

    do_reset();
    check1("reset_ready", {31'd0, lsu_ready}, 32'd1);
    check1("reset_en", {31'd0, rf_wrt_en}, 32'd0);

    // Table: single-cycle ALU path and scoreboard visibility.
    for (int i = 0; i < 6; i++) begin
      set_alu(vecs[i].av, vecs[i].ad, vecs[i].ax);
      iss_valid = vecs[i].iv;
      iss_dest  = vecs[i].id;
      step();
      check1($sformatf("vec%0d_en", i), {31'd0, rf_wrt_en}, {31'd0, vecs[i].exp_en});
      chk_pend($sformatf("vec%0d_pend", i), vecs[i].q, vecs[i].exp_pend);
    end
    iss_valid = 1'b0;
    check1("vec0_data_gone", {31'd0, rf_wrt_en}, 32'd0);

    // Issue then long-latency completion to dest 7.
    iss_valid = 1'b1;
    iss_dest  = 5'd7;
    step();
    iss_valid = 1'b0;
    chk_pend("t2_pend_iss", 5'd7, 1'b1);
    check1("t2_ready", {31'd0, lsu_ready}, 32'd1);
    set_lsu(1'b1, 5'd7, 32'h0000_1234);
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      check1($sformatf("t2_en_c%0d", c), {31'd0, rf_wrt_en}, {31'd0, (c == LSU_LAT)});
      if (c == LSU_LAT) begin
        check1("t2_dest", {27'd0, rf_wrt_dest}, 32'd7);
        check1("t2_data", rf_wrt_data, 32'h0000_1234);
      end
      chk_pend($sformatf("t2_pend_c%0d", c), 5'd7, (c < LSU_LAT));
      step();
    end

    // ALU stream starves the FIFO until it fills.
    li = 0;
    for (int k = 0; k < 6; k++) begin
      set_alu(1'b1, AW'(10 + k), 32'hA000 + k);
      check1($sformatf("t3_ready_k%0d", k), {31'd0, lsu_ready}, {31'd0, (k < 4)});
      acc = lsu_ready;
      set_lsu(1'b1, AW'(20 + li), 32'hB000 + li);
      step();
      if (acc) li++;
    end
    set_alu(1'b0, 5'd0, 32'd0);
    for (int w = 0; w < 20 && li < 5; w++) begin
      acc = lsu_ready;
      set_lsu(1'b1, AW'(20 + li), 32'hB000 + li);
      step();
      if (acc) li++;
    end
    set_lsu(1'b0, 5'd0, 32'd0);
    check1("t3_all_accepted", li, 32'd5);
    for (int w = 0; w < 8; w++) step();
    check1("t3_drained", alu_q.size() + lsu_q.size(), 32'd0);

    // Dest-0 long-latency result is consumed silently.
    set_lsu(1'b1, 5'd0, 32'h0000_0055);
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      check1($sformatf("t4_en_c%0d", c), {31'd0, rf_wrt_en}, 32'd0);
      chk_pend($sformatf("t4_pend0_c%0d", c), 5'd0, 1'b0);
      step();
    end
    set_lsu(1'b1, 5'd6, 32'h0000_0066);
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
    step();
    step();
    check1("t4_after_dest0", lsu_q.size(), 32'd0);

    // Same-cycle re-issue of dest 3 and retirement of the older dest-3 result.
    iss_valid = 1'b1;
    iss_dest  = 5'd3;
    step();
    iss_valid = 1'b0;
    set_lsu(1'b1, 5'd3, 32'h0000_0033);
`ifdef WB_BYPASS_EN
    iss_valid = 1'b1;
`endif
    step();
    set_lsu(1'b0, 5'd0, 32'd0);
`ifndef WB_BYPASS_EN
    iss_valid = 1'b1;
    step();
`endif
    iss_valid = 1'b0;
    check1("t5_written", {31'd0, rf_wrt_en}, 32'd1);
    chk_pend("t5_pend3", 5'd3, 1'b1);
    step();
    chk_pend("t5_pend3_hold", 5'd3, 1'b1);

    // Reset with three buffered entries and pending bits set.
    for (int k = 0; k < 3; k++) begin
      set_alu(1'b1, 5'd2, 32'hC0 + k);
      iss_valid = 1'b1;
      iss_dest  = AW'(11 + k);
      set_lsu(1'b1, AW'(11 + k), 32'hD0 + k);
      step();
    end
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    iss_valid = 1'b0;
    chk_pend("t6_pre_pend12", 5'd12, 1'b1);
    do_reset();
    check1("t6_ready", {31'd0, lsu_ready}, 32'd1);
    chk_pend("t6_pend11", 5'd11, 1'b0);
    chk_pend("t6_pend13", 5'd13, 1'b0);
    chk_pend("t6_pend3", 5'd3, 1'b0);
    for (int c = 0; c < 6; c++) begin
      check1($sformatf("t6_quiet_c%0d", c), {31'd0, rf_wrt_en}, 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
